// File: rtl/writeback_regfile_pkg.sv
// Shared writeback-stage constants: register file geometry and the bit layout
// of the WB control field carried by the upstream MEM/WB pipeline register.
package writeback_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // Bit positions inside the 2-bit WB control field.
  localparam int WB_CTRL_W       = 2;
  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WB_CTRL_W-1:0]  wb_ctrl_t;

endpackage

// File: rtl/writeback_regfile_wb_mux.sv
// Writeback source select: load data or ALU result, purely combinational.
module wb_mux
  import writeback_regfile_pkg::*;
(
  input  logic  mem_to_reg_i,
  input  data_t mem_data_i,
  input  data_t reg_data_i,
  output data_t wb_data_o
);

  assign wb_data_o = mem_to_reg_i ? mem_data_i : reg_data_i;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus 32x32 register file with optional same-cycle write
// forwarding to both read ports and a wrapping count of committed writes.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  data_t            MemData_i,
  input  data_t            RegData_i,
  input  reg_addr_t        RegAddr_i,
  input  reg_addr_t        RS1addr_i,
  input  reg_addr_t        RS2addr_i,
  output data_t            RS1data_o,
  output data_t            RS2data_o,
  output data_t            WBdata_o,
  output logic             WBvalid_o,
  output logic [CNT_W-1:0] WrCount_o
);

  data_t            wb_data;
  logic             wb_valid;
  data_t            regs_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  wb_mux u_wb_mux (
    .mem_to_reg_i (MemtoReg_i),
    .mem_data_i   (MemData_i),
    .reg_data_i   (RegData_i),
    .wb_data_o    (wb_data)
  );

  // A write to x0 is not a commit: it neither changes state nor counts.
  assign wb_valid  = RegWrite_i && (RegAddr_i != '0);
  assign WBdata_o  = wb_data;
  assign WBvalid_o = wb_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid) begin
      regs_q[RegAddr_i] <= wb_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WrCount_o = cnt_q;

  // Forwarding stays live during reset so the bypass path mirrors WBdata_o.
  always_comb begin
    RS1data_o = (RS1addr_i == '0) ? '0 : regs_q[RS1addr_i];
    RS2data_o = (RS2addr_i == '0) ? '0 : regs_q[RS2addr_i];
    if (BYPASS != 0 && wb_valid) begin
      if (RS1addr_i == RegAddr_i) begin
        RS1data_o = wb_data;
      end
      if (RS2addr_i == RegAddr_i) begin
        RS2data_o = wb_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: three instances (bypass, no bypass, 4-bit
// counter) share one stimulus stream and are compared to a behavioural model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] mem_data;
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;

  logic [31:0] b_rs1, b_rs2, b_wbd, b_cnt;
  logic        b_wbv;
  logic [31:0] n_rs1, n_rs2, n_wbd, n_cnt;
  logic        n_wbv;
  logic [31:0] c_rs1, c_rs2, c_wbd;
  logic [3:0]  c_cnt;
  logic        c_wbv;

  int tests;
  int fails;

  logic [31:0] model_regs [32];
  int unsigned model_cnt;

  writeback_regfile #(.BYPASS(1), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
    .MemData_i(mem_data), .RegData_i(reg_data), .RegAddr_i(reg_addr),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RS1data_o(b_rs1), .RS2data_o(b_rs2),
    .WBdata_o(b_wbd), .WBvalid_o(b_wbv), .WrCount_o(b_cnt)
  );

  writeback_regfile #(.BYPASS(0), .CNT_W(32)) dut_n (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
    .MemData_i(mem_data), .RegData_i(reg_data), .RegAddr_i(reg_addr),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RS1data_o(n_rs1), .RS2data_o(n_rs2),
    .WBdata_o(n_wbd), .WBvalid_o(n_wbv), .WrCount_o(n_cnt)
  );

  writeback_regfile #(.BYPASS(1), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
    .MemData_i(mem_data), .RegData_i(reg_data), .RegAddr_i(reg_addr),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RS1data_o(c_rs1), .RS2data_o(c_rs2),
    .WBdata_o(c_wbd), .WBvalid_o(c_wbv), .WrCount_o(c_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_wb();
    return mem_to_reg ? mem_data : reg_data;
  endfunction

  function automatic logic exp_valid();
    return reg_write && (reg_addr != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && exp_valid() && a == reg_addr) return exp_wb();
    if (rst) return 32'h0;
    return model_regs[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 0;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_clear();
    end else if (exp_valid()) begin
      model_regs[reg_addr] = exp_wb();
      model_cnt = model_cnt + 1;
    end
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] md,
                       input logic [31:0] rd, input logic [4:0] wa,
                       input logic [4:0] a1, input logic [4:0] a2);
    reg_write = we; mem_to_reg = m2r; mem_data = md; reg_data = rd;
    reg_addr = wa; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":b_rs1"}, b_rs1, exp_rd(rs1_addr, 1'b1));
    check({tag, ":b_rs2"}, b_rs2, exp_rd(rs2_addr, 1'b1));
    check({tag, ":n_rs1"}, n_rs1, exp_rd(rs1_addr, 1'b0));
    check({tag, ":n_rs2"}, n_rs2, exp_rd(rs2_addr, 1'b0));
    check({tag, ":c_rs1"}, c_rs1, exp_rd(rs1_addr, 1'b1));
    check({tag, ":wbdata"}, b_wbd, exp_wb());
    check({tag, ":wbdata_n"}, n_wbd, exp_wb());
    check({tag, ":wbvalid"}, {31'h0, b_wbv}, {31'h0, exp_valid()});
    check({tag, ":wbvalid_c"}, {31'h0, c_wbv}, {31'h0, exp_valid()});
    check({tag, ":cnt32"}, b_cnt, model_cnt);
    check({tag, ":cnt32_n"}, n_cnt, model_cnt);
    check({tag, ":cnt4"}, {28'h0, c_cnt}, model_cnt % 16);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    model_clear();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Reset: every address reads zero on every port, counters zero.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(a), 5'(31 - a));
      check("rst_rs1", b_rs1, 32'h0);
      check("rst_rs2", n_rs2, 32'h0);
    end
    check("rst_cnt", b_cnt, 32'h0);
    // A valid write held across a reset edge is dropped.
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE_0001, 5'd9, 5'd9, 5'd9);
    check("rst_byp", b_rs1, 32'hCAFE_0001);
    check("rst_nobyp", n_rs1, 32'h0);
    tick();
    check_all("rst_edge");
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd0);
    check("rst_drop", b_rs1, 32'h0);

    // ALU result write to x5 with same-cycle bypass.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
    check("w5_byp", b_rs1, 32'h0000_1234);
    check("w5_nobyp", n_rs1, 32'h0);
    check_all("w5_pre");
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    check("w5_post", b_rs1, 32'h0000_1234);
    check("w5_post_n", n_rs2, 32'h0000_1234);
    check("w5_cnt", b_cnt, 32'd1);

    // Load-data write to x0 is ignored.
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 5'd5);
    check("x0_wbdata", b_wbd, 32'hDEAD_BEEF);
    check("x0_valid", {31'h0, b_wbv}, 32'h0);
    tick();
    check("x0_rd", b_rs1, 32'h0);
    check("x0_cnt", b_cnt, 32'd1);

    // Shared read address, both ports forward (or not).
    drive(1'b1, 1'b1, 32'hA5A5_A5A5, 32'h1111_1111, 5'd7, 5'd7, 5'd7);
    check("x7_b1", b_rs1, 32'hA5A5_A5A5);
    check("x7_b2", b_rs2, 32'hA5A5_A5A5);
    check("x7_n1", n_rs1, 32'h0);
    check("x7_n2", n_rs2, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    check("x7_post_n1", n_rs1, 32'hA5A5_A5A5);
    check("x7_post_n2", n_rs2, 32'hA5A5_A5A5);

    // Randomized traffic, reads biased toward the write address.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom, wa,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      check_all("rand");
      tick();
    end

    // 4-bit counter wraps: 17 commits from reset leave it at 1.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    model_clear();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(i), 5'(1 + (i % 31)), 5'd1, 5'd2);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    check("wrap_cnt4", {28'h0, c_cnt}, 32'd1);
    check("wrap_cnt32", b_cnt, 32'd17);

    // Asynchronous reset between edges clears immediately and drops the edge write.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd3, 5'd3, 5'd3);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd3, 5'd3, 5'd4);
    rst = 1'b1;
    model_clear();
    #1;
    check("arst_n_rs1", n_rs1, 32'h0);
    check("arst_b_byp", b_rs1, 32'h0000_0077);
    check("arst_cnt", b_cnt, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check("arst_drop", b_rs1, 32'h0);
    check_all("arst_hold");

    // Write presented as reset deasserts commits on the next edge.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd3, 5'd3, 5'd3);
    rst = 1'b0;
    #1;
    check("rel_pre", n_rs1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check("rel_post", n_rs1, 32'h0000_0099);
    check("rel_cnt", b_cnt, 32'd1);
    check_all("rel_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have the parameter BYPASS, default 1, meaning that a same-cycle write is forwarded to the read ports when set to 1.
REQ-002 The block SHALL have the parameter CNT_W, default 32, giving the width of the writeback counter.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port RegWrite_i, input, 1 bit: writeback enable from the MEM/WB stage.
REQ-007 The block SHALL have port MemtoReg_i, input, 1 bit: 1 selects MemData_i, 0 selects RegData_i.
REQ-008 The block SHALL have port MemData_i, input, 32 bits: load data.
REQ-009 The block SHALL have port RegData_i, input, 32 bits: ALU result.
REQ-010 The block SHALL have port RegAddr_i, input, 5 bits: destination register.
REQ-011 The block SHALL have ports RS1addr_i and RS2addr_i, input, 5 bits each: read addresses from ID.
REQ-012 The block SHALL have ports RS1data_o and RS2data_o, output, 32 bits each: read data.
REQ-013 The block SHALL have port WBdata_o, output, 32 bits: selected writeback value, combinational, for the forwarding unit.
REQ-014 The block SHALL have port WBvalid_o, output, 1 bit: RegWrite_i asserted and RegAddr_i nonzero.
REQ-015 The block SHALL have port WrCount_o, output, CNT_W bits: count of committed register writes.

Function
REQ-016 WBdata_o SHALL equal MemData_i when MemtoReg_i=1, else RegData_i; this path is purely combinational.
REQ-017 The block SHALL hold 32 registers of 32 bits each, with register 0 hardwired to zero.
REQ-018 On a rising clk_i with WBvalid_o=1, register[RegAddr_i] SHALL load WBdata_o.
REQ-019 Writes with RegAddr_i=0 or RegWrite_i=0 SHALL leave all registers and WrCount_o unchanged.
REQ-020 Reads SHALL be combinational: RSnData_o = register[RSnaddr_i], with address 0 always returning 0.
REQ-021 With BYPASS=1 and WBvalid_o=1 and RSnaddr_i=RegAddr_i, RSnData_o SHALL equal WBdata_o in the same cycle (write-before-read).
REQ-022 With BYPASS=0, the old contents SHALL be returned until the next edge.
REQ-023 Both read ports SHALL bypass independently, and both SHALL bypass when they share an address.
REQ-024 WrCount_o SHALL increment by 1 on each edge where WBvalid_o=1.
REQ-025 WrCount_o SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-026 Write latency is 1 cycle: a value written at edge N is visible without bypass from edge N onward.

Reset
REQ-027 While rst_i=1, all 31 writable registers and WrCount_o SHALL be 0, regardless of clk_i.
REQ-028 A write presented in the cycle when rst_i deasserts SHALL commit at the next rising edge after deassertion.
REQ-029 Assertion of rst_i mid-stream SHALL discard any write coincident with that edge.
REQ-030 RSnData_o SHALL read 0 during reset, except for a bypassed value under BYPASS=1, which still reflects WBdata_o.

Structure
REQ-031 A shared package SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the WB control bit positions (RegWrite=0, MemtoReg=1) used by the upstream pipeline register.
REQ-032 The writeback mux SHALL be one sub-module, wb_mux; the register array, bypass logic, and counter SHALL be inline.

Verification
REQ-033 Reset, then read all addresses -> every port returns 0, and WrCount_o=0.
REQ-034 RegWrite=1, MemtoReg=0, RegData=0x0000_1234, RegAddr=5, RS1addr=5, BYPASS=1 -> RS1data_o=0x1234 in the same cycle; after the edge, with RegWrite=0, RS1data_o=0x1234 and WrCount_o=1.
REQ-035 RegWrite=1, MemtoReg=1, MemData=0xDEAD_BEEF, RegAddr=0 -> after the edge, register 0 reads 0, WBvalid_o=0, and WrCount_o is unchanged.
REQ-036 RS1addr=RS2addr=7 with a bypassed write of 0xA5A5_A5A5 to register 7 -> both ports return 0xA5A5_A5A5; repeat with BYPASS=0 -> both ports return the prior value 0.
REQ-037 With CNT_W=4, perform 17 valid writes -> WrCount_o=1.
REQ-038 Write 0x55 to register 3, then assert rst_i asynchronously between edges -> register 3 reads 0 immediately; a write at the rst_i-asserted edge is dropped.
